add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl_pkg.sv | 12 +
 rtl/add_seq_ctrl_fulladder4.sv | 26 ++
 rtl/add_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state type and nibble width.
package add_seq_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_fulladder4.sv
// fulladder4: purely combinational 4-bit ripple adder slice used by add_seq_ctrl.
module fulladder4
  import add_seq_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_ci,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_co
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = i_ci;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      assign o_s[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_co = w_c[NIBBLE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: adds a_in+b_in+cin one nibble per cycle through one fulladder4.
// Define ADD_SEQ_OVF_EN to add the signed-overflow output ovf.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NNIB  = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic                r_cout;

  logic [IDX_W+1:0]    w_base;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;
  logic                w_last;
  logic                w_accept;

  // Bit offset of the current nibble: index * NIBBLE_W with NIBBLE_W = 4.
  assign w_base   = {r_idx, 2'b00};
  assign w_a_nib  = r_a[w_base +: NIBBLE_W];
  assign w_b_nib  = r_b[w_base +: NIBBLE_W];
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);

  fulladder4 u_fa4 (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

  // Operands are captured only on an accepted start, so later input changes are invisible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a_in;
      r_b     <= b_in;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum[w_base +: NIBBLE_W] <= w_s;
      r_carry                   <= w_co;
      r_idx                     <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef ADD_SEQ_OVF_EN
  logic r_ovf;
  logic w_c_into_msb;

  // Carry into the MSB recovered from the top bit's sum: c = a ^ b ^ s.
  assign w_c_into_msb = w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1] ^ w_s[NIBBLE_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= w_c_into_msb ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: vector table, corner sequences, random ops vs arithmetic model.
module tb_add_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef ADD_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge: presents operands with start for one edge, then scrambles the inputs.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Counts cycles (1 = first cycle after the accepting edge) until done, bounded.
  task automatic wait_done(input int first, output int cyc, output int bc);
    cyc = first;
    bc  = 0;
    while (!done && cyc <= 20) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input int cyc, input int bc, input int exp_bc,
                              input logic exp_ovf);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    $display("op %s: %h + %h + %b -> sum %h cout %b, done at cycle %0d", tag, a, b, c, sum, cout, cyc);
    chk({tag, " done_cycle"}, 32'(cyc), 32'd5);
    chk({tag, " busy_cycles"}, 32'(bc), 32'(exp_bc));
    chk({tag, " sum"}, 32'(sum), 32'(full[W-1:0]));
    chk({tag, " cout"}, 32'(cout), 32'(full[W]));
`ifdef ADD_SEQ_OVF_EN
    chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note %s: unexpected unknown ovf expectation", tag);
`endif
  endtask

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W-1:0] s;
    s = a + b + W'(c);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
    int cyc;
    int bc;
    drive_start(a, b, c);
    wait_done(1, cyc, bc);
    check_result(tag, a, b, c, cyc, bc, 4, model_ovf(a, b, c));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int bc;
    int seen_done;

    vecs[0] = '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum",  32'(sum),  32'd0);
    chk("reset cout", 32'(cout), 32'd0);
`ifdef ADD_SEQ_OVF_EN
    chk("reset ovf",  32'(ovf),  32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      drive_start(vecs[i].a, vecs[i].b, vecs[i].c);
      wait_done(1, cyc, bc);
      $display("vec %0d: %h + %h + %b -> sum %h cout %b", i, vecs[i].a, vecs[i].b, vecs[i].c, sum, cout);
      chk($sformatf("vec%0d done_cycle", i), 32'(cyc), 32'd5);
      chk($sformatf("vec%0d busy_cycles", i), 32'(bc), 32'd4);
      chk($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
`ifdef ADD_SEQ_OVF_EN
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
      @(negedge clk);
      chk($sformatf("vec%0d idle_after_done", i), 32'({busy, done}), 32'd0);
    end

    // Start during busy must be ignored.
    drive_start(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    a_in  = 16'hFFFF;
    b_in  = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, cyc, bc);
    check_result("ignore_busy", 16'h1234, 16'h1111, 1'b0, cyc, bc, 2, 1'b0);
    chk("ignore_busy sum_const", 32'(sum), 32'h2345);
    @(negedge clk);

    // Reset in the second RUN cycle aborts with no done.
    drive_start(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort outputs", 32'({busy, done, cout, sum}), 32'd0);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort no_done", 32'(seen_done), 32'd0);
    do_add(16'h000F, 16'h0001, 1'b0, "after_abort");
    chk("after_abort sum_const", 32'(sum), 32'h0010);

    // Back-to-back: start asserted during DONE is accepted.
    drive_start(16'h0001, 16'h0002, 1'b0);
    wait_done(1, cyc, bc);
    check_result("b2b_first", 16'h0001, 16'h0002, 1'b0, cyc, bc, 4, 1'b0);
    drive_start(16'h00FF, 16'h0001, 1'b0);
    wait_done(1, cyc, bc);
    check_result("b2b_second", 16'h00FF, 16'h0001, 1'b0, cyc, bc, 4, 1'b0);
    chk("b2b_second sum_const", 32'(sum), 32'h0100);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
